// File: rtl/mprv_priv_unit_if.sv
// mprv_priv_unit_if
// Per-port LSU request/response handshake bundle for mprv_priv_unit.
//   req_valid_i / req_ready_o : request handshake, one bit per port
//   rsp_valid_o / rsp_ready_i : tagged-response handshake, one bit per port
//   rsp_priv_o                : tag for port p in bits [2p+1:2p]
// The master modport is the LSU side and the slave modport is the privilege unit.
interface mprv_priv_unit_if #(
   parameter int NUM_PORTS = 2
);
   logic [NUM_PORTS-1:0]   req_valid_i;
   logic [NUM_PORTS-1:0]   req_ready_o;
   logic [NUM_PORTS-1:0]   rsp_valid_o;
   logic [NUM_PORTS-1:0]   rsp_ready_i;
   logic [2*NUM_PORTS-1:0] rsp_priv_o;

   modport master (
      output req_valid_i,
      output rsp_ready_i,
      input  req_ready_o,
      input  rsp_valid_o,
      input  rsp_priv_o
   );

   modport slave (
      input  req_valid_i,
      input  rsp_ready_i,
      output req_ready_o,
      output rsp_valid_o,
      output rsp_priv_o
   );
endinterface

// File: rtl/mprv_priv_unit.sv
// mprv_priv_unit
// Registered effective-privilege unit. It holds the privilege level,
// mstatus.MPRV/MPP, dcsr.mprven and the RUN/DEBUG state. From these it
// derives the effective load/store privilege and tags requests on
// NUM_PORTS independent ports through a one-entry output register per port.
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   mstatus_we_i/...      mstatus MPRV/MPP write (MPP is WARL, 10 -> 00)
//   dcsr_we_i/...         dcsr.mprven write; dcsr_prv_i is the DRET target
//   mret_i, debug_enter_i, dret_i   retirement/debug events
//   lsu_if (slave)        per-port request/response handshake and tags
//   priv_lvl_o, eff_priv_o, mprv_o, mpp_o, debug_mode_o   state view
module mprv_priv_unit #(
   parameter int NUM_PORTS = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  mstatus_we_i,
   input  logic                  mstatus_mprv_i,
   input  logic [1:0]            mstatus_mpp_i,
   input  logic                  dcsr_we_i,
   input  logic                  dcsr_mprven_i,
   input  logic [1:0]            dcsr_prv_i,
   input  logic                  mret_i,
   input  logic                  debug_enter_i,
   input  logic                  dret_i,
   mprv_priv_unit_if.slave       lsu_if,
   output logic [1:0]            priv_lvl_o,
   output logic [1:0]            eff_priv_o,
   output logic                  mprv_o,
   output logic [1:0]            mpp_o,
   output logic                  debug_mode_o
);

   localparam logic [1:0] PRV_U = 2'b00;
   localparam logic [1:0] PRV_M = 2'b11;

   typedef enum logic {ST_RUN = 1'b0, ST_DEBUG = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [1:0] priv_q, priv_d;
   logic       mprv_q, mprv_d;
   logic [1:0] mpp_q, mpp_d;
   logic       mprven_q, mprven_d;
   logic [1:0] eff_priv;

   // 2'b10 is a reserved privilege encoding; it legalises to U.
   function automatic logic [1:0] legalise_prv(input logic [1:0] v);
      return (v == 2'b10) ? PRV_U : v;
   endfunction

   // Events that do not apply in the current state are treated as absent,
   // so they do not mask lower-priority events.
   logic enter_ev, dret_ev, mret_ev;
   assign enter_ev = debug_enter_i && (state_q == ST_RUN);
   assign dret_ev  = dret_i && (state_q == ST_DEBUG);
   assign mret_ev  = mret_i && (state_q == ST_RUN);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_RUN;
         priv_q   <= PRV_M;
         mprv_q   <= 1'b0;
         mpp_q    <= PRV_U;
         mprven_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         priv_q   <= priv_d;
         mprv_q   <= mprv_d;
         mpp_q    <= mpp_d;
         mprven_q <= mprven_d;
      end
   end

   // Next-state logic; only the highest-priority event takes effect.
   always_comb begin
      state_d  = state_q;
      priv_d   = priv_q;
      mprv_d   = mprv_q;
      mpp_d    = mpp_q;
      mprven_d = mprven_q;
      if (enter_ev) begin
         state_d = ST_DEBUG;
      end else if (dret_ev) begin
         state_d = ST_RUN;
         priv_d  = legalise_prv(dcsr_prv_i);
         if (legalise_prv(dcsr_prv_i) != PRV_M) mprv_d = 1'b0;
      end else if (mret_ev) begin
         priv_d = mpp_q;
         mpp_d  = PRV_U;
         if (mpp_q != PRV_M) mprv_d = 1'b0;
      end else begin
         if (mstatus_we_i) begin
            mprv_d = mstatus_mprv_i;
            mpp_d  = legalise_prv(mstatus_mpp_i);
         end
         if (dcsr_we_i) mprven_d = dcsr_mprven_i;
      end
   end

   // Output logic: effective privilege from registered state only.
   always_comb begin
      eff_priv     = priv_q;
      debug_mode_o = 1'b0;
      if (state_q == ST_DEBUG) begin
         debug_mode_o = 1'b1;
         eff_priv     = (mprven_q && mprv_q) ? mpp_q : PRV_M;
      end else if (mprv_q) begin
         eff_priv = mpp_q;
      end
   end

   assign eff_priv_o = eff_priv;
   assign priv_lvl_o = priv_q;
   assign mprv_o     = mprv_q;
   assign mpp_o      = mpp_q;

   // Per-port one-entry output register. A held entry freezes its tag until
   // drained; a drain and a new accept in the same cycle reload the entry.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic       valid_q, valid_d;
      logic [1:0] tag_q, tag_d;
      logic       ready, accept;

      assign ready  = !valid_q || lsu_if.rsp_ready_i[gi];
      assign accept = lsu_if.req_valid_i[gi] && ready;

      always_comb begin
         valid_d = valid_q;
         tag_d   = tag_q;
         if (accept) begin
            valid_d = 1'b1;
            tag_d   = eff_priv;
         end else if (lsu_if.rsp_ready_i[gi]) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= PRV_U;
         end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
         end
      end

      assign lsu_if.req_ready_o[gi]          = ready;
      assign lsu_if.rsp_valid_o[gi]          = valid_q;
      assign lsu_if.rsp_priv_o[2*gi +: 2]    = tag_q;
   end

endmodule

// File: doc/mprv_priv_unit.md
# mprv_priv_unit

Registered effective-privilege unit for the CSR/LSU boundary. It owns the machine-mode privilege state: current privilege, mstatus.MPRV, mstatus.MPP, dcsr.mprven and debug mode. From that state it computes the effective load/store privilege and tags each memory request on NUM_PORTS independent LSU ports through a one-entry output register per port. It generalises the single combinational MPRV select, adding debug entry/exit sequencing, MRET/DRET side effects and per-port handshaking.

## Interface
- NUM_PORTS, default 2: number of independent request ports (1..8).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- mstatus_we_i  in  1  write mstatus fields this cycle.
- mstatus_mprv_i  in  1  MPRV write data.
- mstatus_mpp_i  in  2  MPP write data (WARL).
- dcsr_we_i  in  1  write dcsr.mprven this cycle.
- dcsr_mprven_i  in  1  mprven write data.
- dcsr_prv_i  in  2  privilege to restore on DRET.
- mret_i  in  1  MRET retires this cycle.
- debug_enter_i  in  1  enter debug mode this cycle.
- dret_i  in  1  DRET retires this cycle.
- req_valid_i  in  NUM_PORTS  per-port request valid.
- req_ready_o  out  NUM_PORTS  per-port request ready.
- rsp_valid_o  out  NUM_PORTS  per-port tagged-request valid.
- rsp_ready_i  in  NUM_PORTS  per-port downstream ready.
- rsp_priv_o  out  2*NUM_PORTS  effective privilege for port p in bits [2p+1:2p].
- priv_lvl_o  out  2  current privilege (U=00, S=01, M=11).
- eff_priv_o  out  2  current effective load/store privilege.
- mprv_o  out  1  mstatus.MPRV.
- mpp_o  out  2  mstatus.MPP.
- debug_mode_o  out  1  1 while in the DEBUG state.

## Operation
- State machine: RUN and DEBUG.
  - RUN to DEBUG on debug_enter_i.
  - DEBUG to RUN on dret_i. dret_i in RUN is ignored.
  - debug_enter_i in DEBUG is ignored.
- Reset values:
  - priv=11, mprv=0, mpp=00, mprven=0, state RUN.
  - All rsp_valid_o=0, so every rsp_priv_o=00.
  - eff_priv_o=11, debug_mode_o=0.
- Event priority when several occur in one cycle: debug_enter_i > dret_i > mret_i > CSR writes. Only the highest-priority event takes effect.
- mret_i (RUN only; ignored in DEBUG):
  - priv <= mpp, and mpp <= 00.
  - If the old mpp != 11, then mprv <= 0.
- dret_i (DEBUG only):
  - priv <= dcsr_prv_i, where 10 maps to 00.
  - If that value != 11, then mprv <= 0.
- mstatus write:
  - mprv <= mstatus_mprv_i.
  - mpp <= mstatus_mpp_i, where 10 maps to 00 (WARL).
- dcsr write: mprven <= dcsr_mprven_i. It is accepted in both states.
- A mstatus write and a dcsr write in the same cycle (no higher event) both apply.
- Effective privilege, combinational from registered state:
  - RUN: mprv ? mpp : priv.
  - DEBUG: (mprven && mprv) ? mpp : 11.
  - MPRV is therefore ignored in debug mode unless mprven=1.
- Per-port output register:
  - req_ready_o[p] = !rsp_valid_o[p] || rsp_ready_i[p].
  - On req_valid_i[p] && req_ready_o[p], capture the current eff_priv and set rsp_valid_o[p].
  - The register clears when rsp_ready_i[p] is high and no new accept occurs.
- Ports are fully independent; there is no arbitration between them.

## Timing
- State and event updates become visible on priv_lvl_o, eff_priv_o, mprv_o, mpp_o and debug_mode_o one cycle after the event edge.
- Requests accepted in the same cycle as an event are tagged with the pre-event eff_priv.
- Request-to-response latency is exactly one cycle. Back-to-back throughput is one per cycle per port when rsp_ready_i is held high.
- While rsp_valid_o[p]=1 and rsp_ready_i[p]=0:
  - rsp_priv_o[p] holds stable even if eff_priv changes.
  - req_ready_o[p]=0.
- Simultaneous drain and accept on a port: the new tag loads and rsp_valid_o stays 1.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous), and pending responses are dropped.

## Test plan
- Reset, then write mstatus mprv=1, mpp=00: eff_priv_o goes 11 to 00 one cycle after the write. A port-0 request two cycles later gets rsp_priv=00.
- mpp=01, mprv=1, then mret_i: the next cycle shows priv_lvl_o=01, mpp_o=00, mprv_o=0, eff_priv_o=01.
- mprv=1, mpp=00, mprven=0, then debug_enter_i: eff_priv_o=11. Write dcsr mprven=1: eff_priv_o=00. dret_i with dcsr_prv_i=00: debug_mode_o=0, mprv_o=0, eff_priv_o=00.
- debug_enter_i and mret_i in the same cycle: enter DEBUG, priv and mpp unchanged. mstatus write with mpp=10: mpp_o=00.
- Port 1 with rsp_ready_i low for 3 cycles while eff_priv changes 11 to 00: rsp_priv_o[3:2] stays 11 and req_ready_o[1]=0. Both ports streaming with ready high: one response per cycle each.
- rst_i pulsed while rsp_valid_o=11: outputs clear asynchronously to rsp_valid_o=00, priv_lvl_o=11.
